bounce_sequence_monitor: RTL and testbench

BOUNCE_SEQUENCE_MONITOR -- requirements
Module: bounce_sequence_monitor

---
 rtl/bounce_sequence_monitor_if.sv | 28 ++
 rtl/bounce_sequence_monitor.sv | 141 ++++++++++++++
 tb/tb_bounce_sequence_monitor.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/bounce_sequence_monitor_if.sv
// Sample/clear inputs and registered status outputs of the bounce sequence monitor.
// The master side drives the samples and the slave side is the monitor.
interface bounce_sequence_monitor_if #(
  parameter int CNT_W = 8
);
  logic             clear;
  logic             valid;
  logic [2:0]       n;
  logic             locked;
  logic             dir_up;
  logic [2:0]       expected_n;
  logic [CNT_W-1:0] bounce_count;
  logic             error_pulse;
  logic [CNT_W-1:0] error_count;
  logic             error_seen;

  modport master (
    output clear, valid, n,
    input  locked, dir_up, expected_n, bounce_count,
    input  error_pulse, error_count, error_seen
  );

  modport slave (
    input  clear, valid, n,
    output locked, dir_up, expected_n, bounce_count,
    output error_pulse, error_count, error_seen
  );
endinterface

// File: rtl/bounce_sequence_monitor.sv
// Tracks a 0..7 up/down bounce counter, counts reversals and flags sequence breaks.
// 1-cycle latency, all outputs registered; no backpressure, valid=0 holds everything.
module bounce_sequence_monitor #(
  parameter int CNT_W = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  bounce_sequence_monitor_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [2:0]       last_n_q, last_n_d;
  logic             dir_up_q, dir_up_d;
  logic [2:0]       expected_q, expected_d;
  logic [CNT_W-1:0] bounce_q, bounce_d;
  logic             err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_seen_q, err_seen_d;

  logic             step_legal;
  logic             step_match;

  // Next value along the current direction; the ends fold back instead of wrapping.
  function automatic logic [2:0] next_expected(input logic [2:0] last, input logic up);
    if (up) begin
      return (last == 3'd7) ? 3'd6 : last + 3'd1;
    end
    return (last == 3'd0) ? 3'd1 : last - 3'd1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  assign step_legal = ((last_n_q != 3'd7) && (bus.n == last_n_q + 3'd1)) ||
                      ((last_n_q != 3'd0) && (bus.n == last_n_q - 3'd1));
  assign step_match = (bus.n == expected_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      last_n_q    <= 3'd0;
      dir_up_q    <= 1'b0;
      expected_q  <= 3'd0;
      bounce_q    <= '0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
      err_seen_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_n_q    <= last_n_d;
      dir_up_q    <= dir_up_d;
      expected_q  <= expected_d;
      bounce_q    <= bounce_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
      err_seen_q  <= err_seen_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = IDLE;
    end else if (bus.valid) begin
      case (state_q)
        IDLE:    state_d = ACQUIRE;
        ACQUIRE: state_d = step_legal ? LOCKED : ACQUIRE;
        LOCKED:  state_d = step_match ? LOCKED : ACQUIRE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    last_n_d    = last_n_q;
    dir_up_d    = dir_up_q;
    expected_d  = expected_q;
    bounce_d    = bounce_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    err_seen_d  = err_seen_q;
    if (bus.clear) begin
      last_n_d   = 3'd0;
      dir_up_d   = 1'b0;
      expected_d = 3'd0;
      bounce_d   = '0;
      err_cnt_d  = '0;
      err_seen_d = 1'b0;
    end else if (bus.valid) begin
      last_n_d = bus.n;
      case (state_q)
        ACQUIRE: begin
          if (step_legal) begin
            dir_up_d = (bus.n > last_n_q);
          end else begin
            err_pulse_d = 1'b1;
            err_cnt_d   = sat_inc(err_cnt_q);
            err_seen_d  = 1'b1;
          end
        end
        LOCKED: begin
          if (step_match) begin
            // Matching a sample taken at either end is a reversal.
            if (last_n_q == 3'd7) begin
              dir_up_d = 1'b0;
              bounce_d = sat_inc(bounce_q);
            end else if (last_n_q == 3'd0) begin
              dir_up_d = 1'b1;
              bounce_d = sat_inc(bounce_q);
            end
          end else begin
            err_pulse_d = 1'b1;
            err_cnt_d   = sat_inc(err_cnt_q);
            err_seen_d  = 1'b1;
          end
        end
        default: ;
      endcase
      expected_d = (state_d == LOCKED) ? next_expected(last_n_d, dir_up_d) : 3'd0;
    end
  end

  assign bus.locked       = (state_q == LOCKED);
  assign bus.dir_up       = dir_up_q;
  assign bus.expected_n   = expected_q;
  assign bus.bounce_count = bounce_q;
  assign bus.error_pulse  = err_pulse_q;
  assign bus.error_count  = err_cnt_q;
  assign bus.error_seen   = err_seen_q;

endmodule

// File: tb/tb_bounce_sequence_monitor.sv
// Directed bench for bounce_sequence_monitor: main instance at CNT_W=8, second at CNT_W=2.
module tb_bounce_sequence_monitor;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  bounce_sequence_monitor_if #(.CNT_W(8)) bus  ();
  bounce_sequence_monitor_if #(.CNT_W(2)) bus2 ();

  bounce_sequence_monitor #(.CNT_W(8)) dut  (.clk(clk), .reset(reset), .bus(bus));
  bounce_sequence_monitor #(.CNT_W(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic clr, input logic v, input logic [2:0] nn);
    bus.clear = clr;
    bus.valid = v;
    bus.n     = nn;
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
    bus.valid = 1'b0;
  endtask

  task automatic send2(input logic clr, input logic v, input logic [2:0] nn);
    bus2.clear = clr;
    bus2.valid = v;
    bus2.n     = nn;
    @(posedge clk);
    #1;
    bus2.clear = 1'b0;
    bus2.valid = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".locked"},  {31'd0, bus.locked}, 32'd0);
    check({tag, ".dir_up"},  {31'd0, bus.dir_up}, 32'd0);
    check({tag, ".exp"},     {29'd0, bus.expected_n}, 32'd0);
    check({tag, ".bounce"},  {24'd0, bus.bounce_count}, 32'd0);
    check({tag, ".epulse"},  {31'd0, bus.error_pulse}, 32'd0);
    check({tag, ".ecount"},  {24'd0, bus.error_count}, 32'd0);
    check({tag, ".eseen"},   {31'd0, bus.error_seen}, 32'd0);
  endtask

  int sweep [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};

  task automatic run_sweep(input string tag);
    for (int i = 0; i < 16; i++) begin
      send(1'b0, 1'b1, 3'(sweep[i]));
      check($sformatf("%s.locked%0d", tag, i), {31'd0, bus.locked}, (i >= 1) ? 32'd1 : 32'd0);
      if (i == 8)  check({tag, ".bounce_7to6"}, {24'd0, bus.bounce_count}, 32'd1);
      if (i == 15) check({tag, ".bounce_0to1"}, {24'd0, bus.bounce_count}, 32'd2);
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.clear  = 1'b0; bus.valid  = 1'b0; bus.n  = 3'd0;
    bus2.clear = 1'b0; bus2.valid = 1'b0; bus2.n = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("rst");
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Full sweep with both reversals.
    run_sweep("sweep");
    check("sweep.ecount", {24'd0, bus.error_count}, 32'd0);
    check("sweep.dir_up", {31'd0, bus.dir_up}, 32'd1);
    check("sweep.exp",    {29'd0, bus.expected_n}, 32'd2);

    // clear beats valid.
    send(1'b1, 1'b1, 3'd5);
    check_zero("clr1");
    send(1'b0, 1'b1, 3'd5);
    check("clr1.idle_no_lock", {31'd0, bus.locked}, 32'd0);
    check("clr1.idle_no_err",  {31'd0, bus.error_pulse}, 32'd0);
    send(1'b1, 1'b0, 3'd0);

    // Start at the top.
    send(1'b0, 1'b1, 3'd7);
    send(1'b0, 1'b1, 3'd6);
    check("top.locked", {31'd0, bus.locked}, 32'd1);
    check("top.dir_up", {31'd0, bus.dir_up}, 32'd0);
    check("top.exp",    {29'd0, bus.expected_n}, 32'd5);
    check("top.bounce", {24'd0, bus.bounce_count}, 32'd0);
    send(1'b0, 1'b1, 3'd5);
    check("top.epulse", {31'd0, bus.error_pulse}, 32'd0);
    check("top.ecount", {24'd0, bus.error_count}, 32'd0);
    send(1'b1, 1'b0, 3'd0);

    // Violation while locked, then resync going up.
    send(1'b0, 1'b1, 3'd2);
    send(1'b0, 1'b1, 3'd3);
    check("viol.locked_pre", {31'd0, bus.locked}, 32'd1);
    send(1'b0, 1'b1, 3'd5);
    check("viol.epulse", {31'd0, bus.error_pulse}, 32'd1);
    check("viol.ecount", {24'd0, bus.error_count}, 32'd1);
    check("viol.eseen",  {31'd0, bus.error_seen}, 32'd1);
    check("viol.locked", {31'd0, bus.locked}, 32'd0);
    send(1'b0, 1'b0, 3'd0);
    check("viol.epulse_gone", {31'd0, bus.error_pulse}, 32'd0);
    send(1'b0, 1'b1, 3'd6);
    check("resync.locked", {31'd0, bus.locked}, 32'd1);
    check("resync.dir_up", {31'd0, bus.dir_up}, 32'd1);
    check("resync.exp",    {29'd0, bus.expected_n}, 32'd7);
    check("resync.eseen",  {31'd0, bus.error_seen}, 32'd1);
    check("resync.ecount", {24'd0, bus.error_count}, 32'd1);
    send(1'b1, 1'b0, 3'd0);

    // Gaps between samples hold everything.
    send(1'b0, 1'b1, 3'd3);
    for (int i = 0; i < 5; i++) begin
      send(1'b0, 1'b0, 3'd4);
      check($sformatf("gap1.locked%0d", i), {31'd0, bus.locked}, 32'd0);
    end
    send(1'b0, 1'b1, 3'd4);
    for (int i = 0; i < 5; i++) begin
      send(1'b0, 1'b0, 3'd0);
      check($sformatf("gap2.locked%0d", i), {31'd0, bus.locked}, 32'd1);
      check($sformatf("gap2.exp%0d", i),    {29'd0, bus.expected_n}, 32'd5);
    end
    send(1'b0, 1'b1, 3'd5);
    check("gap.epulse", {31'd0, bus.error_pulse}, 32'd0);
    check("gap.exp",    {29'd0, bus.expected_n}, 32'd6);

    // Stall while locked is a violation.
    send(1'b0, 1'b1, 3'd5);
    check("stall.epulse", {31'd0, bus.error_pulse}, 32'd1);
    check("stall.locked", {31'd0, bus.locked}, 32'd0);
    send(1'b1, 1'b0, 3'd0);

    // 7 -> 0 is not a legal acquire step (no wrap).
    send(1'b0, 1'b1, 3'd7);
    send(1'b0, 1'b1, 3'd0);
    check("wrap.epulse", {31'd0, bus.error_pulse}, 32'd1);
    check("wrap.locked", {31'd0, bus.locked}, 32'd0);
    send(1'b1, 1'b0, 3'd0);

    // Saturation on the narrow instance.
    send2(1'b0, 1'b1, 3'd0);
    for (int i = 0; i < 5; i++) send2(1'b0, 1'b1, 3'd0);
    check("sat.ecount", {30'd0, bus2.error_count}, 32'd3);
    check("sat.eseen",  {31'd0, bus2.error_seen}, 32'd1);
    send2(1'b1, 1'b1, 3'd1);
    check("sat.clr_ecount", {30'd0, bus2.error_count}, 32'd0);
    check("sat.clr_eseen",  {31'd0, bus2.error_seen}, 32'd0);
    check("sat.clr_locked", {31'd0, bus2.locked}, 32'd0);
    check("sat.clr_exp",    {29'd0, bus2.expected_n}, 32'd0);
    send2(1'b0, 1'b1, 3'd0);
    check("sat.idle_no_err", {31'd0, bus2.error_pulse}, 32'd0);

    // Async reset mid-sequence, between edges.
    run_sweep("pre_rst");
    #2;
    reset = 1'b0;
    #1;
    check_zero("arst");
    @(posedge clk);
    #1;
    reset = 1'b1;
    send(1'b0, 1'b1, 3'd4);
    check("post_rst.locked", {31'd0, bus.locked}, 32'd0);
    check("post_rst.epulse", {31'd0, bus.error_pulse}, 32'd0);
    send(1'b0, 1'b1, 3'd5);
    check("post_rst.lock2", {31'd0, bus.locked}, 32'd1);
    check("post_rst.exp",   {29'd0, bus.expected_n}, 32'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
